rms_denorm: RTL
===============

# rms_denorm

Inverse of the RMS normalisation stage: accepts one normalised `vector_t` plus the fixed-point RMS scale that was divided out. It rescales every element by that scale, one element per cycle, and presents the restored vector on a valid/ready output. It sits in the FU cluster next to the RMS unit. It restores activation magnitude ahead of the residual add and uses the same `config_pkg` vector and fixed-point types.

## Interface
- `D` (package constant, default from `config_pkg`): elements per vector.
- `FixedPointWidth` (package constant, bench value 16): total bits of `fixed_point_t`, two's complement.
- `FixedPointFrac` (package constant, bench value 8): fractional bits of `fixed_point_t`.
- Clock and reset: one clock; reset is asynchronous and active-high.
- `clk_i` input 1: the single clock.
- `rst_i` input 1: asynchronous, active-high reset.
- `in_ready_o` output 1: high only in IDLE and never while `rst_i` is high.
- `in_valid_i` input 1: `a_i` and `scale_i` are valid.
- `a_i` input `vector_t`: normalised vector.
- `scale_i` input `fixed_point_t`: RMS value to multiply back in.
- `out_valid_o` output 1: `result_o` and `sat_o` are valid; held until accepted.
- `out_ready_i` input 1: downstream accepts the result.
- `result_o` output `vector_t`: rescaled vector (registered).
- `sat_o` output 1: at least one element saturated in the presented vector.

## Operation
- States: IDLE, MULTIPLYING, SENDING_OUT.
- IDLE:
  - `in_ready_o`=1.
  - On `in_valid_i`, register `a_i` into `a_q` and `scale_i` into `scale_q`.
  - Clear `idx_q`=0 and `sat_q`=0, then go to MULTIPLYING.
  - Inputs are not sampled after the accepting edge, so the upstream may change them freely.
- MULTIPLYING:
  - Each cycle, `out_q[idx_q]` = mul(`a_q[idx_q]`, `scale_q`) and `sat_q` |= element saturated.
  - `idx_q`++.
  - When `idx_q` reaches D-1 on this cycle's write, go to SENDING_OUT with `idx_q`=0.
- SENDING_OUT:
  - `out_valid_o`=1.
  - On `out_ready_i`, go to IDLE.
  - `result_o` and `sat_o` stay stable while `out_valid_o` is high and not accepted.
- Arithmetic:
  - The product is a signed 2·FixedPointWidth-bit value, arithmetically shifted right by FixedPointFrac (truncation toward −∞).
  - The result then saturates to [FixedPointMin, FixedPointMax].
  - An element is saturated iff the shifted product lies outside that range.
- `scale_q`=0 gives an all-zero vector with `sat_o`=0.
- Negative scale is legal and is multiplied as signed.
- `result_o` keeps the last vector's values after acceptance until overwritten element by element during the next MULTIPLYING.

## Timing
- Accepting edge t, where `in_valid_i`&&`in_ready_o`.
- MULTIPLYING occupies cycles t+1 … t+D.
- `out_valid_o` rises in cycle t+D+1.
- Minimum occupancy is D+2 cycles per vector; there is no overlap between vectors.
- `in_ready_o` is 0 from t+1 until the cycle after the output handshake.
- Simultaneous `out_valid_o`&&`out_ready_i` and a new `in_valid_i`: the new vector is not accepted in that cycle. It is accepted in the following IDLE cycle.
- Reset values:
  - Reset (async assert, any state) forces IDLE.
  - `idx_q`=0, `a_q`=0, `scale_q`=0, `out_q`=0, `sat_q`=0.
  - `out_valid_o`=0, `result_o`=0, `sat_o`=0, `in_ready_o`=0.
- Reset mid-MULTIPLYING or mid-SENDING_OUT discards the vector; no partial output is ever flagged valid.
- After release, `in_ready_o`=1 on the first cycle.

## Structure
- Add to `config_pkg`: `FixedPointWidth`, `FixedPointFrac`, `FixedPointMax`, `FixedPointMin`.
- `fixed_point_t`/`vector_t` are reused from the package; no local copies.
- One sub-module, `rowwise_mul`, is the combinational counterpart of `rowwise_div`.
  - Ports: `a_i`, `b_i` (`fixed_point_t`), `y_o` (`fixed_point_t`), `sat_o`.
  - It is reusable by other FUs.
- The FSM, index counter (`$clog2(D)+1` bits) and the vector registers stay in `rms_denorm`.

## Test plan
- Reset release, idle: `in_ready_o`=1, `out_valid_o`=0, `result_o`=0.
- Unity scale: D=8, scale=0x0100 (1.0), a={1.0, −1.0, 0.5, …} → result identical to input.
  - `out_valid_o` first high exactly D+1 cycles after acceptance; `sat_o`=0.
- Scaling and rounding: scale=0x0180 (1.5), a[0]=0x0003 → 0x0004; a[1]=0xFFFD → 0xFFFB (floor of −4.5 LSB).
- Saturation: scale=0x7FFF, a[2]=0x4000 → 0x7FFF; a[3]=0xC000 → 0x8000; `sat_o`=1.
  - A following vector with no overflow → `sat_o`=0.
- Backpressure: hold `out_ready_i`=0 for 5 cycles, with `a_i`/`scale_i` changed after acceptance.
  - `result_o` is stable and correct and `in_ready_o` stays 0.
  - Release → IDLE next cycle.
- Reset mid-operation: assert `rst_i` asynchronously at element 3 of MULTIPLYING.
  - Outputs zero immediately, no `out_valid_o`.
  - The next vector processes correctly from `idx`=0.

Source files
------------

// File: rtl/config_pkg.sv
// Shared configuration for the FU cluster: vector geometry, fixed-point
// format and the state type of the RMS de-normalisation unit.
package config_pkg;

  localparam int D               = 8;
  localparam int FixedPointWidth = 16;
  localparam int FixedPointFrac  = 8;

  typedef logic signed [FixedPointWidth-1:0] fixed_point_t;
  typedef fixed_point_t [D-1:0] vector_t;

  localparam fixed_point_t FixedPointMax = {1'b0, {(FixedPointWidth-1){1'b1}}};
  localparam fixed_point_t FixedPointMin = {1'b1, {(FixedPointWidth-1){1'b0}}};

  // One spare bit so the element index can be compared against D-1 for any D.
  localparam int IdxWidth = $clog2(D) + 1;

  typedef enum logic [1:0] {
    IDLE        = 2'd0,
    MULTIPLYING = 2'd1,
    SENDING_OUT = 2'd2
  } denorm_state_e;

endpackage

// File: rtl/rowwise_mul.sv
// Combinational fixed-point multiply: full-width signed product, arithmetic
// shift by the fractional bits (floor), then saturation to the fixed-point range.
module rowwise_mul
  import config_pkg::*;
(
  input  fixed_point_t a_i,
  input  fixed_point_t b_i,
  output fixed_point_t y_o,
  output logic         sat_o
);

  localparam int ProdWidth = 2 * FixedPointWidth;
  localparam logic signed [ProdWidth-1:0] WideMax = ProdWidth'(FixedPointMax);
  localparam logic signed [ProdWidth-1:0] WideMin = ProdWidth'(FixedPointMin);

  logic signed [ProdWidth-1:0] prod;
  logic signed [ProdWidth-1:0] shifted;

  // Multiply, rescale and clamp; sat_o flags any element that had to be clamped.
  always_comb begin
    prod    = ProdWidth'(a_i) * ProdWidth'(b_i);
    shifted = prod >>> FixedPointFrac;
    y_o     = shifted[FixedPointWidth-1:0];
    sat_o   = 1'b0;
    if (shifted > WideMax) begin
      y_o   = FixedPointMax;
      sat_o = 1'b1;
    end else if (shifted < WideMin) begin
      y_o   = FixedPointMin;
      sat_o = 1'b1;
    end
  end

endmodule

// File: rtl/rms_denorm.sv
// RMS de-normalisation: captures one vector plus its RMS scale, multiplies the
// scale back into one element per cycle, then holds the restored vector on a
// valid/ready output until it is taken.
//
// Handshakes: a transfer happens on a rising clk edge where valid and ready are
// both high; valid, once raised, stays high with stable data until that edge,
// and ready may be raised or dropped freely.
module rms_denorm
  import config_pkg::*;
(
  input  logic          clk_i,
  input  logic          rst_i,
  output logic          in_ready_o,
  input  logic          in_valid_i,
  input  vector_t       a_i,
  input  fixed_point_t  scale_i,
  output logic          out_valid_o,
  input  logic          out_ready_i,
  output vector_t       result_o,
  output logic          sat_o,
  output denorm_state_e state_o
);

  denorm_state_e         state_q;
  logic [IdxWidth-1:0]   idx_q;
  logic [IdxWidth-2:0]   idx_lo;
  vector_t               a_q;
  fixed_point_t          scale_q;
  vector_t               out_q;
  logic                  sat_q;
  logic                  out_valid_q;
  fixed_point_t          mul_y;
  logic                  mul_sat;

  assign idx_lo = idx_q[IdxWidth-2:0];

  rowwise_mul u_mul (
    .a_i   (a_q[idx_lo]),
    .b_i   (scale_q),
    .y_o   (mul_y),
    .sat_o (mul_sat)
  );

  // Control FSM plus the datapath registers it sequences.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      a_q         <= '0;
      scale_q     <= '0;
      out_q       <= '0;
      sat_q       <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid_i) begin
            a_q     <= a_i;
            scale_q <= scale_i;
            idx_q   <= '0;
            sat_q   <= 1'b0;
            state_q <= MULTIPLYING;
          end
        end
        MULTIPLYING: begin
          out_q[idx_lo] <= mul_y;
          sat_q         <= sat_q | mul_sat;
          if (idx_q == IdxWidth'(D - 1)) begin
            idx_q       <= '0;
            out_valid_q <= 1'b1;
            state_q     <= SENDING_OUT;
          end else begin
            idx_q <= idx_q + 1'b1;
          end
        end
        SENDING_OUT: begin
          if (out_ready_i) begin
            out_valid_q <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: begin
          out_valid_q <= 1'b0;
          state_q     <= IDLE;
        end
      endcase
    end
  end

  // Ready is masked by reset so nothing can be accepted while it is held.
  assign in_ready_o  = (state_q == IDLE) && !rst_i;
  assign out_valid_o = out_valid_q;
  assign result_o    = out_q;
  assign sat_o       = sat_q;
  assign state_o     = state_q;

endmodule
